// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin arbiter sharing the fifo_ctrl write port; optional WR_ARB_PRIO_EN gives requester 0 priority
module fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wr_full,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [DSIZE-1:0]      wr_data,
    output logic                  wr_inc,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            owner_req;
    logic            rr_found;
    int              rr_idx;
    logic [PW-1:0]   rr_pick;
    logic [PW-1:0]   next_ptr;
    logic [PW-1:0]   release_ptr;

    // Owner's request line; owner_q never exceeds NREQ-1.
    always_comb begin
        owner_req = req[owner_q];
    end

    // Pick the first requester scanning from rr_ptr upward with wrap.
    always_comb begin
        rr_pick  = rr_ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = PW'(rr_idx);
                rr_found = 1'b1;
            end
        end
`ifdef WR_ARB_PRIO_EN
        // Requester 0 wins every arbitration it takes part in.
        if (req[0]) begin
            rr_pick = '0;
        end
`endif
    end

    // Pointer to hand out after the current owner lets go.
    always_comb begin
        next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef WR_ARB_PRIO_EN
        // Owner 0 is a priority winner, so it does not advance the rotation.
        release_ptr = (owner_q == '0) ? rr_ptr_q : next_ptr;
`else
        release_ptr = next_ptr;
`endif
    end

    // State register with asynchronous reset.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, count words and release in GRANT.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = rr_pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Early release: no write this cycle.
                    state_d  = IDLE;
                    rr_ptr_d = release_ptr;
                end else if (!wr_full) begin
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = release_ptr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // wr_full with req held: stall, owner and cnt unchanged.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: all zero outside GRANT, owner's slot gated by wr_full inside.
    always_comb begin
        gnt     = '0;
        ack     = '0;
        wr_data = '0;
        wr_inc  = 1'b0;
        busy    = 1'b0;
        if (state_q == GRANT) begin
            busy         = 1'b1;
            gnt[owner_q] = 1'b1;
            wr_inc       = owner_req & ~wr_full;
            ack          = gnt & {NREQ{wr_inc}};
            wr_data      = req_data[owner_q*DSIZE +: DSIZE];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb
module tb_fifo_wr_arb;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  wr_clk = 1'b0;
    logic                  wr_rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wr_full;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [DSIZE-1:0]      wr_data;
    logic                  wr_inc;
    logic                  busy;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wr_clk   (wr_clk),
        .wr_rst   (wr_rst),
        .req      (req),
        .req_data (req_data),
        .wr_full  (wr_full),
        .gnt      (gnt),
        .ack      (ack),
        .wr_data  (wr_data),
        .wr_inc   (wr_inc),
        .busy     (busy)
    );

    typedef struct {
        int         who;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[NREQ][$];
    logic [3:0] acked;
    int         vectors     = 0;
    int         miscompares = 0;
    int         wr_seen     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] word(input int who, input int k);
        return 8'(16 * (who + 1) + k);
    endfunction

    task automatic load(input int who, input int first, input int n);
        for (int k = 0; k < n; k++) src_q[who].push_back(word(who, first + k));
    endtask

    task automatic expect_burst(input int who, input int first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.who  = who;
            e.data = word(who, first + k);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    function automatic int src_pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_pending() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size() + src_pending()), 0);
        tick();
        tick();
        tick();
    endtask

    task automatic wait_writes(input string name, input int target);
        int n = 0;
        while (wr_seen < target && n < 100) begin
            tick();
            n++;
        end
        check({name, "_wait"}, 32'(wr_seen >= target), 1);
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        tick();
        tick();
        wr_rst = 1'b0;
    endtask

    // Requester model: hold slot until acked, then present the next word.
    initial begin
        req      = '0;
        req_data = '0;
        acked    = '0;
        forever begin
            @(negedge wr_clk);
            acked = ack;
            @(posedge wr_clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (acked[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            #1;
            for (int i = 0; i < NREQ; i++) begin
                req[i]                   = (src_q[i].size() > 0);
                req_data[i*DSIZE +: DSIZE] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
            end
        end
    end

    // Monitor: every write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge wr_clk);
            if (wr_inc) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'h0, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", {24'h0, wr_data}, {24'h0, e.data});
                    check("wr_gnt", {28'h0, gnt}, 32'(1 << e.who));
                    check("wr_ack", {28'h0, ack}, 32'(1 << e.who));
                end
            end else begin
                check("noack_without_write", {28'h0, ack}, 0);
            end
            check("busy_vs_gnt", {31'h0, busy}, {31'h0, (gnt != 4'b0)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        wr_rst  = 1'b1;
        wr_full = 1'b0;

        // Reset held with all four requesters active.
        for (int i = 0; i < NREQ; i++) begin
            load(i, 0, 1);
            expect_burst(i, 0, 1);
        end
        repeat (5) begin
            @(negedge wr_clk);
            check("rst_gnt", {28'h0, gnt}, 0);
            check("rst_ack", {28'h0, ack}, 0);
            check("rst_wr_inc", {31'h0, wr_inc}, 0);
            check("rst_wr_data", {24'h0, wr_data}, 0);
            check("rst_busy", {31'h0, busy}, 0);
        end
        check("rst_req_seen", {28'h0, req}, 32'hF);
        tick();
        wr_rst = 1'b0;
        drain("t1", 100);

        // Single requester 2, three words, then release.
        load(2, 0, 3);
        expect_burst(2, 0, 3);
        @(negedge wr_clk);
        check("t2_gnt_before", {28'h0, gnt}, 0);
        @(negedge wr_clk);
        check("t2_gnt", {28'h0, gnt}, 32'h4);
        check("t2_inc0", {31'h0, wr_inc}, 1);
        @(negedge wr_clk);
        check("t2_inc1", {31'h0, wr_inc}, 1);
        @(negedge wr_clk);
        check("t2_inc2", {31'h0, wr_inc}, 1);
        @(negedge wr_clk);
        check("t2_inc_release", {31'h0, wr_inc}, 0);
        drain("t2a", 100);
        // Pointer now at 3: requester 3 beats requester 0.
        load(0, 8, 1);
        load(3, 8, 1);
        expect_burst(3, 8, 1);
        expect_burst(0, 8, 1);
        drain("t2b", 100);

        // All four streaming.
        do_reset();
        load(0, 0, 8);
        load(1, 0, 4);
        load(2, 0, 4);
        load(3, 0, 4);
`ifdef WR_ARB_PRIO_EN
        expect_burst(0, 0, 8);
        expect_burst(1, 0, 4);
        expect_burst(2, 0, 4);
        expect_burst(3, 0, 4);
`else
        expect_burst(0, 0, 4);
        expect_burst(1, 0, 4);
        expect_burst(2, 0, 4);
        expect_burst(3, 0, 4);
        expect_burst(0, 4, 4);
`endif
        drain("t3", 300);

        // wr_full stall after the second word.
        do_reset();
        load(1, 0, 6);
        expect_burst(1, 0, 6);
        wait_writes("t4", wr_seen + 2);
        wr_full = 1'b1;
        repeat (5) begin
            @(negedge wr_clk);
            check("t4_stall_inc", {31'h0, wr_inc}, 0);
            check("t4_stall_ack", {28'h0, ack}, 0);
            check("t4_stall_gnt", {28'h0, gnt}, 32'h2);
        end
        tick();
        wr_full = 1'b0;
        @(negedge wr_clk);
        check("t4_word3", {31'h0, wr_inc}, 1);
        @(negedge wr_clk);
        check("t4_word4", {31'h0, wr_inc}, 1);
        @(negedge wr_clk);
        check("t4_burst_end_gap", {31'h0, wr_inc}, 0);
        @(negedge wr_clk);
        check("t4_regrant", {31'h0, wr_inc}, 1);
        drain("t4", 100);

        // Reset pulsed mid-burst.
        do_reset();
        load(1, 0, 4);
        expect_burst(1, 0, 2);
        wait_writes("t5", wr_seen + 2);
        #2;
        wr_rst = 1'b1;
        #1;
        check("t5_gnt", {28'h0, gnt}, 0);
        check("t5_ack", {28'h0, ack}, 0);
        check("t5_wr_inc", {31'h0, wr_inc}, 0);
        check("t5_wr_data", {24'h0, wr_data}, 0);
        check("t5_busy", {31'h0, busy}, 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        for (int i = 0; i < NREQ; i++) begin
            load(i, 12, 1);
            expect_burst(i, 12, 1);
        end
        tick();
        tick();
        wr_rst = 1'b0;
        @(negedge wr_clk);
        check("t5_idle_after_rst", {28'h0, gnt}, 0);
        @(negedge wr_clk);
        check("t5_first_gnt", {28'h0, gnt}, 32'h1);
        drain("t5", 100);

        // req = 1011 held.
        do_reset();
        load(0, 0, 8);
        load(1, 0, 4);
        load(3, 0, 4);
`ifdef WR_ARB_PRIO_EN
        expect_burst(0, 0, 8);
        expect_burst(1, 0, 4);
        expect_burst(3, 0, 4);
`else
        expect_burst(0, 0, 4);
        expect_burst(1, 0, 4);
        expect_burst(3, 0, 4);
        expect_burst(0, 4, 4);
`endif
        drain("t6", 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
